// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for lock with a timeout,
// qualifies lock as stable and then releases the video-domain reset request.
// Everything runs on the board reference clock that also feeds the PLL.
module pll_lock_sequencer #(
    parameter int unsigned RST_PULSE_CYC   = 100,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned LOCK_STABLE_CYC = 1000,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       video_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_lost_cnt
);

    typedef enum logic [2:0] {
        S_RST_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lock_sync;
    logic             lock_s;
    logic [3:0]       retry_next;

    assign lock_s     = lock_sync[1];
    assign retry_next = retry_cnt + 4'd1;

    // Two-flop synchronizer for the asynchronous PLL lock pin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[0], pll_lock};
        end
    end

    // Sequencer FSM; outputs are registered from the current state, so they
    // follow a state change by one cycle. ready/video_rst_n are additionally
    // qualified by lock_s so they drop the cycle after lock_s falls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_RST_PLL;
            cnt           <= '0;
            pll_reset     <= 1'b1;
            video_rst_n   <= 1'b0;
            ready         <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= '0;
            lock_lost_cnt <= '0;
        end else begin
            pll_reset   <= (state == S_RST_PLL) || (state == S_FAIL);
            video_rst_n <= (state == S_RUN) && lock_s;
            ready       <= (state == S_RUN) && lock_s;
            fail        <= (state == S_FAIL);

            // Default: count while the state holds; every transition below
            // overrides this with a clear.
            cnt <= cnt + 1'b1;

            case (state)
                S_RST_PLL: begin
                    if (cnt == PULSE_LAST) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_cnt <= retry_next;
                        state     <= (retry_next == RETRY_LIMIT) ? S_FAIL : S_RST_PLL;
                        cnt       <= '0;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= S_RUN;
                        retry_cnt <= '0;
                        cnt       <= '0;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state <= S_RST_PLL;
                        cnt   <= '0;
                        if (lock_lost_cnt != 8'hFF) begin
                            lock_lost_cnt <= lock_lost_cnt + 8'd1;
                        end
                    end
                end
                S_FAIL: begin
                    if (restart) begin
                        state     <= S_RST_PLL;
                        retry_cnt <= '0;
                        cnt       <= '0;
                    end
                end
                default: begin
                    state <= S_RST_PLL;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized bench for pll_lock_sequencer: a phase/age reference model steps
// on every clock edge and every output is compared on the falling edge.
module tb_pll_lock_sequencer;

    localparam int PULSE   = 4;
    localparam int TIMEOUT = 20;
    localparam int STABLE  = 8;
    localparam int RETRIES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       restart;
    logic       pll_reset;
    logic       video_rst_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_lost_cnt;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_PULSE_CYC   (PULSE),
        .LOCK_TIMEOUT_CYC(TIMEOUT),
        .LOCK_STABLE_CYC (STABLE),
        .MAX_RETRY       (RETRIES),
        .CNT_W           (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .restart      (restart),
        .pll_reset    (pll_reset),
        .video_rst_n  (video_rst_n),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .lock_lost_cnt(lock_lost_cnt)
    );

    // Reference model. Phases: 0 reset pulse, 1 waiting for lock,
    // 2 qualifying lock, 3 running, 4 failed. 'age' is time spent in phase.
    int m_phase = 0;
    int m_age   = 0;
    int m_retry = 0;
    int m_lost  = 0;
    bit m_pin_d1 = 0, m_pin_d2 = 0;  // pin delayed by one and two edges
    bit e_prst = 1, e_vrst = 0, e_ready = 0, e_fail = 0;

    always @(posedge clk) begin
        int next_phase;
        bit seen;
        cyc++;
        if (!rst_n) begin
            m_phase = 0; m_age = 0; m_retry = 0; m_lost = 0;
            m_pin_d1 = 0; m_pin_d2 = 0;
            e_prst = 1; e_vrst = 0; e_ready = 0; e_fail = 0;
        end else begin
            seen = m_pin_d2;
            e_prst  = (m_phase == 0) || (m_phase == 4);
            e_ready = (m_phase == 3) && seen;
            e_vrst  = e_ready;
            e_fail  = (m_phase == 4);
            next_phase = m_phase;
            if (m_phase == 0) begin
                if (m_age + 1 >= PULSE) next_phase = 1;
            end else if (m_phase == 1) begin
                if (seen) next_phase = 2;
                else if (m_age + 1 >= TIMEOUT) begin
                    m_retry = m_retry + 1;
                    next_phase = (m_retry >= RETRIES) ? 4 : 0;
                end
            end else if (m_phase == 2) begin
                if (!seen) next_phase = 1;
                else if (m_age + 1 >= STABLE) begin
                    next_phase = 3;
                    m_retry = 0;
                end
            end else if (m_phase == 3) begin
                if (!seen) begin
                    next_phase = 0;
                    m_lost = (m_lost < 255) ? m_lost + 1 : 255;
                end
            end else begin
                if (restart) begin
                    next_phase = 0;
                    m_retry = 0;
                end
            end
            m_age    = (next_phase != m_phase) ? 0 : m_age + 1;
            m_phase  = next_phase;
            m_pin_d2 = m_pin_d1;
            m_pin_d1 = pll_lock;
        end
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Let one rising edge act on the current inputs, then compare everything.
    task automatic tick();
        @(negedge clk);
        check("pll_reset",     {7'd0, pll_reset},   {7'd0, e_prst});
        check("video_rst_n",   {7'd0, video_rst_n}, {7'd0, e_vrst});
        check("ready",         {7'd0, ready},       {7'd0, e_ready});
        check("fail",          {7'd0, fail},        {7'd0, e_fail});
        check("retry_cnt",     {4'd0, retry_cnt},   8'(m_retry));
        check("lock_lost_cnt", lock_lost_cnt,       8'(m_lost));
    endtask

    initial begin
        int unsigned kind;
        int unsigned len;
        logic        lvl;

        rst_n = 1'b0; pll_lock = 1'b0; restart = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;

        // Random lock behaviour: short glitches, medium runs and long holds
        // (long lows exercise timeouts and the failed state).
        for (int e = 0; e < 180; e++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       len = $urandom_range(1, 3);
                1:       len = $urandom_range(5, 15);
                default: len = $urandom_range(20, 70);
            endcase
            lvl = (kind == 0) ? ~pll_lock : 1'($urandom_range(0, 1));
            for (int c = 0; c < int'(len); c++) begin
                pll_lock = lvl;
                restart  = ($urandom_range(0, 24) == 0);
                rst_n    = ($urandom_range(0, 399) != 0);
                tick();
            end
        end

        // Repeated lock losses to drive the loss counter into saturation.
        rst_n = 1'b1;
        restart = 1'b1;
        pll_lock = 1'b1;
        tick();
        restart = 1'b0;
        for (int l = 0; l < 270; l++) begin
            pll_lock = 1'b1;
            for (int c = 0; c < 26 + int'($urandom_range(0, 6)); c++) tick();
            pll_lock = 1'b0;
            for (int c = 0; c < 3; c++) tick();
        end
        pll_lock = 1'b1;
        for (int c = 0; c < 30; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls the DVI clock PLL from the reference-clock side.
- Pulses the PLL reset and waits, with a timeout, for the PLL lock output.
- Qualifies lock as stable, then releases the video-domain reset request.
- On loss of lock it re-arms the PLL automatically; after repeated lock timeouts it reports a hard failure.
- Runs entirely on the 50 MHz board clock that feeds the PLL, so it never depends on PLL output clocks.

Parameters:
- RST_PULSE_CYC, 100: PLL reset pulse width in clk cycles (2 us at 50 MHz); minimum 1.
- LOCK_TIMEOUT_CYC, 50000: maximum cycles to wait for lock after a reset pulse; minimum 2.
- LOCK_STABLE_CYC, 1000: consecutive synchronized-lock cycles required before release; minimum 1.
- MAX_RETRY, 3: lock timeouts tolerated before FAIL; minimum 1.
- CNT_W, 16: width of the shared cycle counter; must hold max(all *_CYC) - 1.

Ports:
- clk, input, 1: 50 MHz reference clock (same net as the PLL clkin).
- rst_n, input, 1: synchronous active-low reset.
- pll_lock, input, 1: PLL lock output; asynchronous to clk.
- restart, input, 1: single-cycle pulse; leaves FAIL and re-arms the sequence.
- pll_reset, output, 1: active-high reset to the PLL.
- video_rst_n, output, 1: active-low reset request to the pixel/serial domains (each domain synchronizes it locally).
- ready, output, 1: clocks locked and stable.
- fail, output, 1: retry budget exhausted.
- retry_cnt, output, 4: lock timeouts since the last successful lock or restart.
- lock_lost_cnt, output, 8: saturating count of lock losses in RUN.

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - state to RST_PLL, counter to 0;
  - pll_reset=1, video_rst_n=0, ready=0, fail=0;
  - retry_cnt=0, lock_lost_cnt=0.
- pll_lock passes through a 2-flop synchronizer to give lock_s; all decisions use lock_s. Both sync flops reset to 0.
- All outputs are registered and decoded from state; an output changes the cycle after the state transition.
- The counter clears on every state change and increments each cycle while the state is unchanged.
- RST_PLL:
  - pll_reset=1.
  - When cnt == RST_PULSE_CYC-1, go to WAIT_LOCK.
  - pll_reset is therefore high for exactly RST_PULSE_CYC cycles after rst_n deasserts or after each re-entry.
- WAIT_LOCK:
  - pll_reset=0.
  - If lock_s=1, go to STABLE.
  - Otherwise, if cnt == LOCK_TIMEOUT_CYC-1, increment retry_cnt; go to FAIL if the new value equals MAX_RETRY, else go to RST_PLL.
  - If lock_s=1 and the timeout occur in the same cycle, lock wins.
- STABLE:
  - If lock_s=0, return to WAIT_LOCK with a fresh timeout and no retry increment.
  - If cnt == LOCK_STABLE_CYC-1 with lock_s=1, go to RUN and clear retry_cnt.
- RUN:
  - video_rst_n=1, ready=1.
  - If lock_s=0, go to RST_PLL and increment lock_lost_cnt, saturating at 255.
  - video_rst_n and ready drop the cycle after lock_s falls, i.e. 3 clk after the pll_lock pin falls.
- FAIL:
  - fail=1, pll_reset=1 (PLL held in reset), video_rst_n=0, ready=0.
  - Stays in FAIL until a restart pulse.
  - restart moves to RST_PLL and clears retry_cnt; fail drops the next cycle.
  - restart is ignored in every state except FAIL.
- rst_n low in any state returns everything to reset values on that edge, including mid-pulse and while in RUN.
- Minimum latency from the pll_lock pin rising (while in WAIT_LOCK) to ready=1 is 2 + 1 + LOCK_STABLE_CYC + 1 clk.

Test Plan:
Bench parameters: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRY=2.
1. Release rst_n, then raise pll_lock 10 clk after pll_reset falls -> pll_reset high exactly 4 clk; ready and video_rst_n go 1 exactly 12 clk after pll_lock rises; retry_cnt=0.
2. Hold pll_lock=0 -> pll_reset repulses 4 clk after the 20-clk timeout with retry_cnt=1; after the second timeout fail=1, pll_reset=1, retry_cnt=2. A restart pulse then gives fail=0 and a 4-clk pll_reset pulse with retry_cnt=0.
3. Glitch pll_lock low for 3 clk during STABLE -> no ready; the stable count restarts, and ready appears 12 clk after the final rise; retry_cnt unchanged.
4. In RUN, drop pll_lock -> ready and video_rst_n fall 3 clk later, lock_lost_cnt=1, and a new 4-clk pll_reset pulse follows. Repeat 260 losses -> lock_lost_cnt holds at 255.
5. Assert rst_n low for 1 clk mid pll_reset pulse and again during RUN -> all outputs at reset values next edge; the full sequence restarts.
6. Pulse restart while in RUN and while in WAIT_LOCK -> no state change, no output change.
